// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 Set-2 scan-code
//               decoder: decoder state encoding, prefix/control byte
//               values, modifier key codes and bit positions in `mods`.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Decoder FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,  // waiting for the first byte of a sequence
    ST_EXT    = 3'd1,  // seen E0
    ST_BRK    = 3'd2,  // seen F0
    ST_EXTBRK = 3'd3,  // seen E0 F0
    ST_SKIP   = 3'd4   // discarding the tail of an E1 (Pause) sequence
  } ps2_dec_state_t;

  // Prefix / control bytes
  localparam logic [7:0] C_E0 = 8'hE0;
  localparam logic [7:0] C_E1 = 8'hE1;
  localparam logic [7:0] C_F0 = 8'hF0;
  localparam logic [7:0] C_AA = 8'hAA;  // BAT passed
  localparam logic [7:0] C_FA = 8'hFA;  // ACK
  localparam logic [7:0] C_FE = 8'hFE;  // resend
  localparam logic [7:0] C_EE = 8'hEE;  // echo
  localparam logic [7:0] C_00 = 8'h00;  // overrun / error
  localparam logic [7:0] C_FF = 8'hFF;  // overrun / error

  // Modifier key codes
  localparam logic [7:0] C_LSHIFT = 8'h12;
  localparam logic [7:0] C_RSHIFT = 8'h59;
  localparam logic [7:0] C_CTRL   = 8'h14;
  localparam logic [7:0] C_ALT    = 8'h11;
  localparam logic [7:0] C_CAPS   = 8'h58;

  // Bit positions inside mods = {caps_lock, alt, ctrl, rshift, lshift}
  localparam int MOD_LSHIFT = 0;
  localparam int MOD_RSHIFT = 1;
  localparam int MOD_CTRL   = 2;
  localparam int MOD_ALT    = 3;
  localparam int MOD_CAPS   = 4;
  localparam int MOD_W      = 5;

  // Bytes the keyboard emits to flag a receive overrun or key-detection error
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == C_00) || (b == C_FF);
  endfunction

  // Keyboard status/response bytes that carry no key information
  function automatic logic is_status_byte(input logic [7:0] b);
    return (b == C_AA) || (b == C_FA) || (b == C_FE) || (b == C_EE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder_if
// Description : Bundles the receiver-FIFO side (byte + pop strobe) and the
//               key-event side (valid/ready handshake + event fields,
//               modifier state, error pulse) of the scan-code decoder.
// Ports       : none; modports
//               slave  - decoder view (consumes bytes, produces events)
//               master - environment view (supplies bytes, sinks events)
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_decoder_if;

  logic [7:0] ps2_data;        // head-of-FIFO byte
  logic       ps2_ready;       // FIFO non-empty
  logic       ps2_nextdata_n;  // active-low pop strobe
  logic       ev_valid;        // event register holds an event
  logic       ev_ready;        // consumer accepts the event
  logic [7:0] ev_code;         // scan code, prefixes stripped
  logic       ev_ext;          // E0-prefixed
  logic       ev_break;        // 1 = release
  logic       ev_repeat;       // typematic repeat
  logic [4:0] mods;            // {caps_lock, alt, ctrl, rshift, lshift}
  logic       err;             // one-cycle error pulse

  modport slave (
    input  ps2_data, ps2_ready, ev_ready,
    output ps2_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
           mods, err
  );

  modport master (
    output ps2_data, ps2_ready, ev_ready,
    input  ps2_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
           mods, err
  );

endinterface
`default_nettype wire

// File: rtl/ps2_modifier_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_modifier_tracker
// Description : Keeps live modifier state from decoded key events. Shift,
//               ctrl and alt follow make/break; caps_lock toggles on a
//               fresh (non-repeat) press of the Caps Lock key.
// Ports       : clk        - system clock
//               clrn       - asynchronous active-low reset
//               ev_stb_i   - an event is being produced this cycle
//               code_i     - event scan code
//               ext_i      - event was E0-prefixed
//               brk_i      - event is a release
//               rep_i      - event is a typematic repeat
//               mods_o     - {caps_lock, alt, ctrl, rshift, lshift}
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_modifier_tracker
  import ps2_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             clrn,
  input  wire logic             ev_stb_i,
  input  wire logic [7:0]       code_i,
  input  wire logic             ext_i,
  input  wire logic             brk_i,
  input  wire logic             rep_i,
  output      logic [MOD_W-1:0] mods_o
);

  logic [MOD_W-1:0] mods_q;
  logic [MOD_W-1:0] mods_d;

  always_comb begin
    mods_d = mods_q;
    if (ev_stb_i) begin
      // Shifts have no E0 variant; E0 12 / E0 59 are fake shifts.
      if (!ext_i && code_i == C_LSHIFT) mods_d[MOD_LSHIFT] = ~brk_i;
      if (!ext_i && code_i == C_RSHIFT) mods_d[MOD_RSHIFT] = ~brk_i;
      // Left (plain) and right (E0) ctrl/alt share one bit.
      if (code_i == C_CTRL) mods_d[MOD_CTRL] = ~brk_i;
      if (code_i == C_ALT)  mods_d[MOD_ALT]  = ~brk_i;
      if (!ext_i && code_i == C_CAPS && !brk_i && !rep_i)
        mods_d[MOD_CAPS] = ~mods_q[MOD_CAPS];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mods_q <= '0;
    end else begin
      mods_q <= mods_d;
    end
  end

  assign mods_o = mods_q;

endmodule
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_decoder
// Description : Turns raw Set-2 scan-code bytes from the PS/2 receiver FIFO
//               into single key events (make/break, E0 flag, typematic
//               repeat flag) with live modifier state, one event at a time
//               over a valid/ready handshake.
// Ports       : clk            - system clock
//               clrn           - asynchronous active-low reset
//               bus (slave)    - ps2_data/ps2_ready in, ps2_nextdata_n out;
//                                ev_valid/ev_ready handshake, ev_code,
//                                ev_ext, ev_break, ev_repeat, mods, err
// Parameters  : E1_SKIP        - bytes discarded after an E1 prefix
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned E1_SKIP = 7
) (
  input wire logic                  clk,
  input wire logic                  clrn,
  ps2_scancode_decoder_if.slave     bus
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  ps2_dec_state_t state_q, state_d;
  logic [7:0]     skip_q, skip_d;
  logic           holdoff_q;
  logic           err_q, err_d;

  logic           ev_valid_q;
  logic [7:0]     ev_code_q;
  logic           ev_ext_q;
  logic           ev_break_q;
  logic           ev_repeat_q;

  logic [8:0]     last_make_q;   // {ext, code}
  logic           last_valid_q;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic           consume;
  logic           produce;
  logic           p_ext;
  logic           p_brk;
  logic           p_rep;
  logic           lm_match;
  logic [8:0]     key;
  logic [MOD_W-1:0] mods;

  // Gating with clrn keeps the pop strobe inactive while held in reset so no
  // byte is lost to a decoder that is not listening.
  assign consume = clrn & bus.ps2_ready & ~holdoff_q &
                   ~(ev_valid_q & ~bus.ev_ready);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    produce = 1'b0;
    p_ext   = 1'b0;
    p_brk   = 1'b0;
    err_d   = 1'b0;

    if (consume) begin
      case (state_q)
        ST_IDLE: begin
          if (is_err_byte(bus.ps2_data)) begin
            err_d = 1'b1;
          end else if (bus.ps2_data == C_E0) begin
            state_d = ST_EXT;
          end else if (bus.ps2_data == C_F0) begin
            state_d = ST_BRK;
          end else if (bus.ps2_data == C_E1) begin
            if (E1_SKIP > 0) begin
              state_d = ST_SKIP;
              skip_d  = 8'(E1_SKIP);
            end
          end else if (!is_status_byte(bus.ps2_data)) begin
            produce = 1'b1;
          end
        end

        ST_EXT: begin
          state_d = ST_IDLE;
          if (is_err_byte(bus.ps2_data)) begin
            err_d = 1'b1;
          end else if (bus.ps2_data == C_F0) begin
            state_d = ST_EXTBRK;
          end else if (bus.ps2_data != C_LSHIFT && bus.ps2_data != C_RSHIFT) begin
            // E0 12 / E0 59 are fake shifts wrapped around navigation keys.
            produce = 1'b1;
            p_ext   = 1'b1;
          end
        end

        ST_BRK, ST_EXTBRK: begin
          state_d = ST_IDLE;
          if (is_err_byte(bus.ps2_data)) begin
            err_d = 1'b1;
          end else begin
            produce = 1'b1;
            p_brk   = 1'b1;
            p_ext   = (state_q == ST_EXTBRK);
          end
        end

        ST_SKIP: begin
          // Pause payload is consumed blindly, error bytes included.
          if (skip_q <= 8'd1) begin
            skip_d  = 8'd0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 8'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Repeat detection against the most recent distinct make
  assign key      = {p_ext, bus.ps2_data};
  assign lm_match = last_valid_q && (last_make_q == key);
  assign p_rep    = produce & ~p_brk & lm_match;

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      skip_q       <= 8'd0;
      holdoff_q    <= 1'b0;
      err_q        <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= 8'd0;
      ev_ext_q     <= 1'b0;
      ev_break_q   <= 1'b0;
      ev_repeat_q  <= 1'b0;
      last_make_q  <= 9'd0;
      last_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      holdoff_q <= consume;  // one-cycle bubble after every pop
      err_q     <= err_d;

      // A consume may coincide with a transfer; the new event then replaces
      // the departing one without a gap.
      if (produce) begin
        ev_valid_q  <= 1'b1;
        ev_code_q   <= bus.ps2_data;
        ev_ext_q    <= p_ext;
        ev_break_q  <= p_brk;
        ev_repeat_q <= p_rep;
      end else if (bus.ev_ready) begin
        ev_valid_q <= 1'b0;
      end

      if (produce && !p_brk && !lm_match) begin
        last_make_q  <= key;
        last_valid_q <= 1'b1;
      end else if (produce && p_brk && lm_match) begin
        last_valid_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Modifier state
  // --------------------------------------------------------------------------
  ps2_modifier_tracker u_mods (
    .clk      (clk),
    .clrn     (clrn),
    .ev_stb_i (produce),
    .code_i   (bus.ps2_data),
    .ext_i    (p_ext),
    .brk_i    (p_brk),
    .rep_i    (p_rep),
    .mods_o   (mods)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ps2_nextdata_n = ~consume;
  assign bus.ev_valid       = ev_valid_q;
  assign bus.ev_code        = ev_code_q;
  assign bus.ev_ext         = ev_ext_q;
  assign bus.ev_break       = ev_break_q;
  assign bus.ev_repeat      = ev_repeat_q;
  assign bus.mods           = mods;
  assign bus.err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_decoder
// Description : Directed self-checking bench for ps2_scancode_decoder. A
//               queue models the receiver FIFO; a negedge monitor records
//               pops, transferred events and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [4:0] mods;
  } ev_t;

  logic clk;
  logic clrn;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.E1_SKIP(7)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fifo[$];
  ev_t        evq[$];
  logic       pop_pending = 1'b0;
  int         pop_cnt     = 0;
  int         err_cnt     = 0;
  int         cyc         = 0;
  int         last_pop    = -10;
  logic       adjacent    = 1'b0;

  // Monitor: sample everything mid-cycle, away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    pop_pending = !bus.ps2_nextdata_n;
    if (pop_pending) begin
      pop_cnt = pop_cnt + 1;
      if (cyc == last_pop + 1) adjacent = 1'b1;
      last_pop = cyc;
    end
    if (bus.err === 1'b1) err_cnt = err_cnt + 1;
    if (bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1)
      evq.push_back('{code: bus.ev_code, ext: bus.ev_ext, brk: bus.ev_break,
                      rep: bus.ev_repeat, mods: bus.mods});
  end

  // FIFO model: retire the popped byte just after the edge, present the next
  always @(posedge clk) begin
    #1;
    if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
    pop_pending   = 1'b0;
    bus.ps2_ready = (fifo.size() > 0);
    bus.ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (fifo.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (fifo.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: fifo has %0d bytes left, required 0", fifo.size());
    end
    tick(8);
  endtask

  // {code, ext, brk, rep} of event i, X when absent
  function automatic logic [10:0] ev_at(input int i);
    if (i < evq.size()) return {evq[i].code, evq[i].ext, evq[i].brk, evq[i].rep};
    return 11'bx;
  endfunction

  function automatic logic [4:0] mods_at(input int i);
    if (i < evq.size()) return evq[i].mods;
    return 5'bx;
  endfunction

  task automatic test_reset();
    clrn = 1'b0;
    bus.ev_ready = 1'b1;
    tick(3);
    checks++;
    if (bus.ps2_nextdata_n !== 1'b1) begin failures++;
      $display("FAIL reset_nextdata_n: got %b, required 1", bus.ps2_nextdata_n); end
    clrn = 1'b1;
    tick(2);
    checks++;
    if (bus.ev_valid !== 1'b0) begin failures++;
      $display("FAIL reset_ev_valid: got %b, required 0", bus.ev_valid); end
    checks++;
    if (bus.mods !== 5'b00000) begin failures++;
      $display("FAIL reset_mods: got %b, required 00000", bus.mods); end
    checks++;
    if (bus.err !== 1'b0) begin failures++;
      $display("FAIL reset_err: got %b, required 0", bus.err); end
  endtask

  task automatic test_make_break();
    evq.delete(); pop_cnt = 0; adjacent = 1'b0;
    feed(8'h1C); feed(8'hF0); feed(8'h1C);
    wait_drain();
    checks++;
    if (evq.size() != 2) begin failures++;
      $display("FAIL mb_count: got %0d events, required 2", evq.size()); end
    checks++;
    if (ev_at(0) !== {8'h1C, 3'b000}) begin failures++;
      $display("FAIL mb_make: got %h, required %h", ev_at(0), {8'h1C, 3'b000}); end
    checks++;
    if (ev_at(1) !== {8'h1C, 3'b010}) begin failures++;
      $display("FAIL mb_break: got %h, required %h", ev_at(1), {8'h1C, 3'b010}); end
    checks++;
    if (pop_cnt != 3) begin failures++;
      $display("FAIL mb_pops: got %0d, required 3", pop_cnt); end
    checks++;
    if (adjacent !== 1'b0) begin failures++;
      $display("FAIL mb_pop_spacing: adjacent pops seen=%b, required 0", adjacent); end
  endtask

  task automatic test_ext_repeat();
    evq.delete();
    feed(8'hE0); feed(8'h75);
    feed(8'hE0); feed(8'h75);
    feed(8'hE0); feed(8'hF0); feed(8'h75);
    wait_drain();
    checks++;
    if (evq.size() != 3) begin failures++;
      $display("FAIL ext_count: got %0d events, required 3", evq.size()); end
    checks++;
    if (ev_at(0) !== {8'h75, 3'b100}) begin failures++;
      $display("FAIL ext_make: got %h, required %h", ev_at(0), {8'h75, 3'b100}); end
    checks++;
    if (ev_at(1) !== {8'h75, 3'b101}) begin failures++;
      $display("FAIL ext_repeat: got %h, required %h", ev_at(1), {8'h75, 3'b101}); end
    checks++;
    if (ev_at(2) !== {8'h75, 3'b110}) begin failures++;
      $display("FAIL ext_break: got %h, required %h", ev_at(2), {8'h75, 3'b110}); end
  endtask

  task automatic test_modifiers();
    logic [10:0] exp_ev[6];
    logic [4:0]  exp_md[6];
    exp_ev = '{{8'h12, 3'b000}, {8'h1C, 3'b000}, {8'h12, 3'b010},
               {8'h58, 3'b000}, {8'h58, 3'b001}, {8'h58, 3'b010}};
    exp_md = '{5'b00001, 5'b00001, 5'b00000, 5'b10000, 5'b10000, 5'b10000};
    evq.delete();
    feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h12);
    feed(8'h58); feed(8'h58); feed(8'hF0); feed(8'h58);
    wait_drain();
    checks++;
    if (evq.size() != 6) begin failures++;
      $display("FAIL mod_count: got %0d events, required 6", evq.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ev_at(i) !== exp_ev[i]) begin failures++;
        $display("FAIL mod_event%0d: got %h, required %h", i, ev_at(i), exp_ev[i]); end
      checks++;
      if (mods_at(i) !== exp_md[i]) begin failures++;
        $display("FAIL mod_mods%0d: got %b, required %b", i, mods_at(i), exp_md[i]); end
    end
    checks++;
    if (bus.mods !== 5'b10000) begin failures++;
      $display("FAIL mod_final: got %b, required 10000", bus.mods); end
  endtask

  task automatic test_pause();
    evq.delete();
    feed(8'hE1); feed(8'h14); feed(8'h77); feed(8'hE1);
    feed(8'hF0); feed(8'h14); feed(8'hF0); feed(8'h77);
    wait_drain();
    checks++;
    if (evq.size() != 0) begin failures++;
      $display("FAIL pause_silent: got %0d events, required 0", evq.size()); end
    feed(8'h29);
    wait_drain();
    checks++;
    if (evq.size() != 1) begin failures++;
      $display("FAIL pause_count: got %0d events, required 1", evq.size()); end
    checks++;
    if (ev_at(0) !== {8'h29, 3'b000}) begin failures++;
      $display("FAIL pause_event: got %h, required %h", ev_at(0), {8'h29, 3'b000}); end
  endtask

  task automatic test_backpressure();
    evq.delete(); pop_cnt = 0;
    bus.ev_ready = 1'b0;
    feed(8'h1C); feed(8'h32);
    tick(20);
    checks++;
    if (bus.ev_valid !== 1'b1) begin failures++;
      $display("FAIL bp_valid: got %b, required 1", bus.ev_valid); end
    checks++;
    if (bus.ev_code !== 8'h1C) begin failures++;
      $display("FAIL bp_code: got %h, required 1c", bus.ev_code); end
    checks++;
    if (fifo.size() != 1 || pop_cnt != 1) begin failures++;
      $display("FAIL bp_no_pop: fifo=%0d pops=%0d, required fifo=1 pops=1", fifo.size(), pop_cnt); end
    bus.ev_ready = 1'b1;
    wait_drain();
    checks++;
    if (evq.size() != 2) begin failures++;
      $display("FAIL bp_count: got %0d events, required 2", evq.size()); end
    checks++;
    if (ev_at(0) !== {8'h1C, 3'b000} || ev_at(1) !== {8'h32, 3'b000}) begin failures++;
      $display("FAIL bp_order: got %h %h, required %h %h", ev_at(0), ev_at(1),
               {8'h1C, 3'b000}, {8'h32, 3'b000}); end
    checks++;
    if (bus.ev_valid !== 1'b0) begin failures++;
      $display("FAIL bp_valid_fall: got %b, required 0", bus.ev_valid); end
  endtask

  task automatic test_reset_mid();
    int err_before;
    feed(8'hE0);
    wait_drain();
    clrn = 1'b0;
    tick(1);
    clrn = 1'b1;
    tick(1);
    checks++;
    if (bus.mods !== 5'b00000) begin failures++;
      $display("FAIL rm_mods: got %b, required 00000", bus.mods); end
    evq.delete();
    feed(8'h1C);
    wait_drain();
    checks++;
    if (evq.size() != 1 || ev_at(0) !== {8'h1C, 3'b000}) begin failures++;
      $display("FAIL rm_event: count=%0d ev=%h, required count=1 ev=%h", evq.size(), ev_at(0),
               {8'h1C, 3'b000}); end
    evq.delete();
    err_before = err_cnt;
    feed(8'hFF);
    wait_drain();
    checks++;
    if (err_cnt - err_before != 1) begin failures++;
      $display("FAIL rm_err_pulse: got %0d cycles, required 1", err_cnt - err_before); end
    checks++;
    if (evq.size() != 0) begin failures++;
      $display("FAIL rm_err_no_event: got %0d events, required 0", evq.size()); end
  endtask

  initial begin
    bus.ps2_data  = 8'h00;
    bus.ps2_ready = 1'b0;
    bus.ev_ready  = 1'b1;
    clrn          = 1'b0;
    test_reset();
    test_make_break();
    test_ext_repeat();
    test_modifiers();
    test_pause();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
